// File: rtl/count_display.sv
// count_display
// Shows the 8-bit count from the upstream counter as a decimal value (0-255)
// on a 4-digit, common-anode, multiplexed 7-segment display.
// A free-running double-dabble converter turns count into BCD once every
// 10 clocks. A prescaler steps the digit scan, and the scan outputs are
// registered.
//
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   count : unsigned binary value to display
//   seg   : segment drive, active-low, {g,f,e,d,c,b,a}
//   an    : digit anodes, active-low, an[0] = ones digit
//   dp    : decimal point, active-low, always off (1)
module count_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int            PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    bin_r;
    logic [11:0]   bcd_r;
    logic [11:0]   bcd_adj_s;
    logic [19:0]   shifted_s;
    logic [2:0]    shcnt_r;
    logic [3:0]    hun_r;
    logic [3:0]    ten_r;
    logic [3:0]    one_r;
    logic [PW-1:0] presc_r;
    logic [1:0]    idx_r;
    logic [3:0]    digit_s;
    logic          blank_s;
    logic [6:0]    seg_s;
    logic [3:0]    an_s;

    // Double-dabble correction: a nibble of 5 or more would overflow
    // past 9 once it is doubled, so it is pre-biased by 3.
    function automatic logic [3:0] dd_adj(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Active-low segment patterns for decimal digits. Any other value is blank.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] res;
        case (d)
            4'd0:    res = 7'h40;
            4'd1:    res = 7'h79;
            4'd2:    res = 7'h24;
            4'd3:    res = 7'h30;
            4'd4:    res = 7'h19;
            4'd5:    res = 7'h12;
            4'd6:    res = 7'h02;
            4'd7:    res = 7'h78;
            4'd8:    res = 7'h00;
            4'd9:    res = 7'h10;
            default: res = 7'h7F;
        endcase
        return res;
    endfunction

    // Converter state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Converter next-state: IDLE for 1 cycle, SHIFT for 8 cycles, DONE for 1 cycle
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:  state_s = SHIFT;
            SHIFT: begin
                if (shcnt_r == 3'd7) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One double-dabble iteration: bias the nibbles, then shift {bcd, bin} left by 1
    always_comb begin
        bcd_adj_s = {dd_adj(bcd_r[11:8]), dd_adj(bcd_r[7:4]), dd_adj(bcd_r[3:0])};
        shifted_s = {bcd_adj_s, bin_r} << 1;
    end

    // Converter datapath. A reset also clears the display registers, so a
    // conversion that is cut short never gets shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_r   <= 8'd0;
            bcd_r   <= 12'd0;
            shcnt_r <= 3'd0;
            hun_r   <= 4'd0;
            ten_r   <= 4'd0;
            one_r   <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    bin_r   <= count;
                    bcd_r   <= 12'd0;
                    shcnt_r <= 3'd0;
                end
                SHIFT: begin
                    {bcd_r, bin_r} <= shifted_s;
                    shcnt_r        <= shcnt_r + 3'd1;
                end
                DONE: begin
                    hun_r <= bcd_r[11:8];
                    ten_r <= bcd_r[7:4];
                    one_r <= bcd_r[3:0];
                end
                default: begin
                    bin_r <= bin_r;
                end
            endcase
        end
    end

    // Scan prescaler and digit index. The index advances when the prescaler wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
        end else if (presc_r == PRESC_MAX) begin
            presc_r <= '0;
            idx_r   <= idx_r + 2'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Digit selection with leading-zero blanking. The ones digit is always shown.
    always_comb begin
        digit_s = 4'd0;
        blank_s = 1'b1;
        case (idx_r)
            2'd0: begin
                digit_s = one_r;
                blank_s = 1'b0;
            end
            2'd1: begin
                digit_s = ten_r;
                blank_s = (hun_r == 4'd0) && (ten_r == 4'd0);
            end
            2'd2: begin
                digit_s = hun_r;
                blank_s = (hun_r == 4'd0);
            end
            default: begin
                digit_s = 4'd0;
                blank_s = 1'b1;
            end
        endcase
        if (blank_s) begin
            seg_s = 7'h7F;
        end else begin
            seg_s = seg_code(digit_s);
        end
        an_s = ~(4'b0001 << idx_r);
    end

    // Output register. Anode and segment values load on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_s;
            seg <= seg_s;
            dp  <= 1'b1;
        end
    end

endmodule
